// File: rtl/missile_sched.sv
// missile_sched: fire-button launch scheduler with cooldown and missile-slot allocation; `MISSILE_AUTOFIRE_EN selects autofire (no HOLD state)
module missile_sched #(
  parameter int SLOTS    = 3,
  parameter int COOLDOWN = 3250000,
  parameter int CW       = 22,
  parameter int SW       = 2
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             fire,
  input  logic             game_en,
  input  logic [SLOTS-1:0] slot_done,
  output logic             launch,
  output logic [SW-1:0]    launch_slot,
  output logic [SLOTS-1:0] slot_busy,
  output logic [3:0]       signal_counter,
  output logic             unlocked
);
`ifdef MISSILE_AUTOFIRE_EN
  typedef enum logic [1:0] {READY, LAUNCH, COOL} state_t;
  localparam state_t COOL_EXIT = READY;
`else
  typedef enum logic [1:0] {READY, LAUNCH, COOL, HOLD} state_t;
  localparam state_t COOL_EXIT = HOLD;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic launch_q, launch_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [SLOTS-1:0] busy_q, busy_d;
  logic [3:0] count_q, count_d;
  logic unlocked_q, unlocked_d;
  logic free_ok, go;
  logic [SW-1:0] free_idx;
  // lowest-index free slot, judged on the registered busy vector so a slot freed this edge is not reused until the next
  always_comb begin
    free_ok = 1'b0;
    free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--)
      if (!busy_q[i]) begin
        free_ok = 1'b1;
        free_idx = SW'(i);
      end
  end
  assign go = (state_q == READY) && fire && game_en && free_ok;
  // next state and cooldown counter; game_en low aborts from any state
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      READY: begin
        state_d = go ? LAUNCH : READY;
        cnt_d = go ? CW'(COOLDOWN - 1) : cnt_q;
      end
      LAUNCH: state_d = COOL;
      COOL: begin
        state_d = (cnt_q == '0) ? COOL_EXIT : COOL;
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
      end
`ifndef MISSILE_AUTOFIRE_EN
      HOLD: state_d = fire ? HOLD : READY;
`endif
      default: state_d = READY;
    endcase
    if (!game_en) begin
      state_d = READY;
      cnt_d = '0;
    end
  end
  // next values of the registered outputs; count and unlocked derive from the next busy vector
  always_comb begin
    launch_d = go;
    slot_d = go ? free_idx : slot_q;
    busy_d = game_en ? ((busy_q & ~slot_done) | (go ? (SLOTS'(1) << free_idx) : '0)) : '0;
    count_d = '0;
    for (int i = 0; i < SLOTS; i++) count_d = count_d + 4'(busy_d[i]);
    unlocked_d = count_d < 4'(SLOTS);
  end
  // state and output registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= READY;
      cnt_q <= '0;
      launch_q <= 1'b0;
      slot_q <= '0;
      busy_q <= '0;
      count_q <= '0;
      unlocked_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      launch_q <= launch_d;
      slot_q <= slot_d;
      busy_q <= busy_d;
      count_q <= count_d;
      unlocked_q <= unlocked_d;
    end
  end
  assign launch = launch_q;
  assign launch_slot = slot_q;
  assign slot_busy = busy_q;
  assign signal_counter = count_q;
  assign unlocked = unlocked_q;
endmodule

// File: tb/tb_missile_sched.sv
// tb_missile_sched: directed and random stimulus against a timestamp-based launch model
module tb_missile_sched;
  localparam int SLOTS = 3, COOLDOWN = 4, CW = 3, SW = 2;
  logic pclk = 1'b0, rst, fire, game_en;
  logic [SLOTS-1:0] slot_done;
  logic launch, unlocked;
  logic [SW-1:0] launch_slot;
  logic [SLOTS-1:0] slot_busy;
  logic [3:0] signal_counter;
  missile_sched #(.SLOTS(SLOTS), .COOLDOWN(COOLDOWN), .CW(CW), .SW(SW)) dut (
    .pclk(pclk), .rst(rst), .fire(fire), .game_en(game_en), .slot_done(slot_done),
    .launch(launch), .launch_slot(launch_slot), .slot_busy(slot_busy),
    .signal_counter(signal_counter), .unlocked(unlocked)
  );
  always #5 pclk = ~pclk;
  int n_checks = 0, n_err = 0;
  int k = 0, m_lock = 0, n_dut = 0;
  bit m_wait = 0, m_launch = 0;
  logic [SW-1:0] m_slot = '0;
  logic [SLOTS-1:0] m_busy = '0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic f, input logic g, input logic [SLOTS-1:0] d, input logic r);
    int idx;
    fire = f;
    game_en = g;
    slot_done = d;
    rst = r;
    @(posedge pclk);
    k++;
    if (r || !g) begin
      m_busy = '0;
      m_launch = 0;
      if (r) m_slot = '0;
      m_lock = k;
      m_wait = 0;
    end else begin
      idx = -1;
      m_launch = 0;
      for (int i = SLOTS - 1; i >= 0; i--) if (!m_busy[i]) idx = i;
      if (k > m_lock) begin
        if (m_wait) begin
          if (!f) m_wait = 0;
        end else if (f && idx >= 0) m_launch = 1;
      end
      m_busy = m_busy & ~d;
      if (m_launch) begin
        m_busy[idx] = 1'b1;
        m_slot = SW'(idx);
        m_lock = k + COOLDOWN + 1;
`ifndef MISSILE_AUTOFIRE_EN
        m_wait = 1;
`endif
      end
    end
    #1;
    if (launch === 1'b1) n_dut++;
    chk("launch", 32'(launch), 32'(m_launch));
    chk("launch_slot", 32'(launch_slot), 32'(m_slot));
    chk("slot_busy", 32'(slot_busy), 32'(m_busy));
    chk("signal_counter", 32'(signal_counter), 32'($countones(m_busy)));
    chk("unlocked", 32'(unlocked), 32'($countones(m_busy) < SLOTS));
  endtask
  initial begin
    int base;
    logic rf;
    // reset held with fire high
    step(1, 1, '0, 1);
    step(1, 1, '0, 1);
    chk("rst_launch", 32'(launch), 0);
    chk("rst_busy", 32'(slot_busy), 0);
    chk("rst_count", 32'(signal_counter), 0);
    chk("rst_unlocked", 32'(unlocked), 1);
    base = n_dut;
    step(1, 1, '0, 0);
    step(1, 1, '0, 0);
    chk("post_rst_launch", 32'(n_dut - base), 1);
    // single pulse
    step(0, 1, '0, 1);
    step(1, 1, '0, 0);
    chk("pulse_launch", 32'(launch), 1);
    chk("pulse_slot", 32'(launch_slot), 0);
    chk("pulse_busy", 32'(slot_busy), 32'b001);
    chk("pulse_count", 32'(signal_counter), 1);
    // held fire then re-press
    step(0, 1, '0, 1);
    base = n_dut;
    repeat (30) step(1, 1, '0, 0);
`ifdef MISSILE_AUTOFIRE_EN
    chk("held_launches", 32'(n_dut - base), 3);
`else
    chk("held_launches", 32'(n_dut - base), 1);
    repeat (2) step(0, 1, '0, 0);
    step(1, 1, '0, 0);
    chk("repress_slot", 32'(launch_slot), 1);
    chk("repress_count", 32'(signal_counter), 2);
    repeat (8) step(0, 1, '0, 0);
    step(1, 1, '0, 0);
    chk("fill_slot", 32'(launch_slot), 2);
    repeat (8) step(0, 1, '0, 0);
    base = n_dut;
    repeat (10) step(1, 1, '0, 0);
    chk("full_no_launch", 32'(n_dut - base), 0);
    chk("full_unlocked", 32'(unlocked), 0);
    chk("full_count", 32'(signal_counter), 3);
    step(0, 1, 3'b010, 0);
    chk("done_count", 32'(signal_counter), 2);
    step(1, 1, '0, 0);
    chk("reuse_slot", 32'(launch_slot), 1);
    chk("reuse_count", 32'(signal_counter), 3);
`endif
    // game_en drop during COOL with a concurrent release
    step(0, 1, '0, 1);
    step(1, 1, '0, 0);
    repeat (8) step(0, 1, '0, 0);
    step(1, 1, '0, 0);
    step(0, 1, '0, 0);
    chk("pre_drop_count", 32'(signal_counter), 2);
    step(0, 0, 3'b001, 0);
    chk("drop_busy", 32'(slot_busy), 0);
    chk("drop_count", 32'(signal_counter), 0);
    chk("drop_unlocked", 32'(unlocked), 1);
    step(1, 1, '0, 0);
    chk("after_drop_launch", 32'(launch), 1);
    chk("after_drop_slot", 32'(launch_slot), 0);
    // random traffic against the model
    rf = 0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 4) == 0) rf = ~rf;
      step(rf, $urandom_range(0, 39) != 0, ($urandom_range(0, 5) == 0) ? SLOTS'($urandom) : '0,
           $urandom_range(0, 199) == 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/missile_sched.md
# missile_sched

Missile-slot scheduler for the player ship. It turns the fire button into launch commands and enforces a cooldown between shots. It allocates each launch to a free missile slot and tracks which slots are airborne. It publishes the live missile count `signal_counter` and a registered `unlocked` flag, which the ship's fire-permission logic uses to gate the weapon.

## Interface
- `SLOTS`, 3, number of missile slots; range 1..15.
- `COOLDOWN`, 3250000, cycles spent in COOL after each launch (50 ms at 65 MHz); must be ≥ 1.
- `CW`, 22, cooldown counter width; must hold `COOLDOWN`.
- `SW`, 2, width of `launch_slot`; equals ceil(log2(SLOTS)), minimum 1.

Ports:
- `pclk`  in  1  system pixel clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fire`  in  1  fire button level, already synchronised and debounced.
- `game_en`  in  1  gameplay active; low aborts and frees all slots.
- `slot_done`  in  SLOTS  per-slot 1-cycle pulse from the missile datapath: missile hit or left screen.
- `launch`  out  1  1-cycle launch strobe.
- `launch_slot`  out  SW  slot index for the current launch; valid while `launch`=1, holds its value otherwise.
- `slot_busy`  out  SLOTS  bit i=1 while slot i is airborne.
- `signal_counter`  out  4  popcount of `slot_busy`.
- `unlocked`  out  1  1 when `signal_counter` < SLOTS.

## Operation
- FSM states: READY, LAUNCH, COOL, HOLD. The reset state is READY.
- READY → LAUNCH when `fire`=1, `game_en`=1 and at least one slot is free. The chosen slot is the lowest-index free slot, evaluated on the `slot_busy` value at that edge.
- In READY, `fire` is ignored while all slots are busy. The FSM stays in READY; no request is queued.
- LAUNCH lasts exactly 1 cycle. During it:
  - `launch`=1 and `launch_slot`=the allocated index.
  - The allocated `slot_busy` bit is already set.
  - The cooldown counter is loaded with `COOLDOWN`-1.
- LAUNCH → COOL unconditionally.
- COOL decrements the counter each cycle. When the counter reaches 0, COOL → HOLD (or → READY; see Configuration).
- HOLD → READY on the first cycle with `fire`=0.
- `slot_done[i]`=1 clears `slot_busy[i]` at the same edge. A pulse for a slot that is not busy is ignored.
- A release and an allocation may occur at the same edge on different slots; both take effect.
- A slot released at edge k is allocatable by a READY decision at edge k+1 or later, never at edge k.
- `signal_counter` and `unlocked` are registered from the next-state `slot_busy`, so they change at the same edge as `slot_busy`.
- `game_en`=0 in any state forces all of the following at the next edge:
  - state → READY;
  - `slot_busy`=0, `signal_counter`=0, `unlocked`=1;
  - `launch`=0 and the cooldown counter cleared.
- `rst` has priority over everything else, and `game_en` over `slot_done` and `fire`.

## Timing
- Reset values: `launch`=0, `launch_slot`=0, `slot_busy`=0, `signal_counter`=0, `unlocked`=1, state READY, cooldown counter 0.
- Latency: `fire` sampled high in READY at edge k → `launch`=1 during the cycle after edge k; `slot_busy`/`signal_counter` are updated at that same edge k.
- Minimum launch-to-launch spacing is 1 (LAUNCH) + `COOLDOWN` (COOL) + 1 (READY decision) = `COOLDOWN`+2 cycles.
- With the autofire macro off, HOLD adds at least one further cycle, because `fire` must be seen low.
- All outputs are registered; there are no combinational input-to-output paths.
- A reset or `game_en` drop during LAUNCH:
  - `launch` deasserts at the next edge;
  - the newly set busy bit is cleared;
  - the datapath must treat the strobe as already issued.

## Configuration
- `MISSILE_AUTOFIRE_EN` defined:
  - COOL → READY directly and the HOLD state is compiled out.
  - A held `fire` relaunches every `COOLDOWN`+2 cycles while a slot is free.
- `MISSILE_AUTOFIRE_EN` undefined:
  - COOL → HOLD, so one press yields one launch.
  - A new launch requires `fire` to return to 0 and then go high again.
- The release is seen in HOLD; a release during COOL is not remembered.

## Test plan
All scenarios use SLOTS=3, COOLDOWN=4, macro off unless noted.
1. Assert `rst` for 2 cycles with `fire`=1 → all outputs at reset values, `unlocked`=1; after release, launch on slot 0 within 2 cycles.
2. `fire` pulse for 1 cycle in READY → exactly one `launch` with `launch_slot`=0 on the next cycle; `signal_counter`=1, `slot_busy`=3'b001.
3. Hold `fire` for 30 cycles → exactly one launch. Release, then press again → second launch with slot 1, `signal_counter`=2, spacing ≥ 7 cycles.
4. Fill all 3 slots, then press again → no `launch`, `unlocked`=0, `signal_counter`=3. Pulse `slot_done[1]`, then press → `signal_counter` 2 then 3, launch on slot 1.
5. Macro defined, `fire` held from idle → launches at cycles t, t+6, t+12 on slots 0, 1, 2; then no further launch until a `slot_done` pulse.
6. Drop `game_en` during COOL with 2 slots busy, with a `slot_done[0]` pulse on the same cycle → next edge `slot_busy`=0, `signal_counter`=0, `unlocked`=1, state READY. Raise `game_en` and press → launch on slot 0.
